// File: rtl/slow_word_uart_dump.sv
// Debug serializer: sends each accepted wide word as 8N1 UART bytes,
// MSB byte first, followed by an idle gap; words arriving while busy are counted.
module slow_word_uart_dump #(
    parameter int DATA_BYTES  = 6,
    parameter int CLK_RATE_HZ = 60_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DEAD_CLKS   = 6000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_data_valid,
    input  logic [8*DATA_BYTES-1:0] i_data,
    output logic                    o_uart_tx,
    output logic                    o_busy,
    output logic [7:0]              o_drop_count
);

    localparam int CLKS_PER_BIT = CLK_RATE_HZ / BAUD_RATE;
    localparam int W  = 8 * DATA_BYTES;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int GW = (DEAD_CLKS > 1) ? $clog2(DEAD_CLKS) : 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(DATA_BYTES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(DEAD_CLKS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("CLKS_PER_BIT must be at least 2");
        end
        if (DEAD_CLKS < 1) begin : g_bad_dead
            $error("DEAD_CLKS must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    state_t          state;
    logic [W-1:0]    word;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [BW-1:0]   byte_idx;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      cur;
    logic            bit_end;

    // The byte on the wire is always the top byte; the word shifts up per byte.
    assign cur     = word[W-1 -: 8];
    assign bit_end = (clk_cnt == CLK_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            word         <= '0;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            gap_cnt      <= '0;
            o_uart_tx    <= 1'b1;
            o_busy       <= 1'b0;
            o_drop_count <= '0;
        end else begin
            if (i_data_valid && state != IDLE && o_drop_count != 8'hFF) begin
                o_drop_count <= o_drop_count + 8'd1;
            end

            unique case (state)
                IDLE: begin
                    if (i_data_valid) begin
                        word      <= i_data;
                        byte_idx  <= '0;
                        clk_cnt   <= '0;
                        state     <= START;
                        o_uart_tx <= 1'b0;
                        o_busy    <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        bit_idx   <= '0;
                        o_uart_tx <= cur[0];
                        state     <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            o_uart_tx <= 1'b1;
                            state     <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            o_uart_tx <= cur[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx == BYTE_LAST) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            byte_idx  <= byte_idx + 1'b1;
                            word      <= word << 8;
                            o_uart_tx <= 1'b0;
                            state     <= START;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    o_uart_tx <= 1'b1;
                    o_busy    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slow_word_uart_dump.sv
// Bench for slow_word_uart_dump: UART line decoder feeding a byte scoreboard,
// table-driven words plus drop, back-to-back, saturation and reset sequences.
module tb_slow_word_uart_dump;

    localparam int DB   = 2;
    localparam int CPB  = 8;
    localparam int DEAD = 4;
    localparam int BUSY = DB * 10 * CPB + DEAD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] data = '0;
    logic        tx;
    logic        busy;
    logic [7:0]  drop;

    slow_word_uart_dump #(
        .DATA_BYTES (DB),
        .CLK_RATE_HZ(8),
        .BAUD_RATE  (1),
        .DEAD_CLKS  (DEAD)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_data_valid(valid),
        .i_data      (data),
        .o_uart_tx   (tx),
        .o_busy      (busy),
        .o_drop_count(drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line decoder: samples mid-bit, a little after each falling clock edge.
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    int         mon_k = 0;
    logic [7:0] mon_byte = '0;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
                mon_k = mon_cnt / CPB;
                if (mon_k == 0) begin
                    check("start bit", {31'd0, tx}, 32'd0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = tx;
                end else begin
                    check("stop bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx byte: got %0h expected none", mon_byte);
                    end else begin
                        check("rx byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [15:0] word;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t vecs[5];

    task automatic send(input logic [15:0] d);
        valid = 1'b1;
        data  = d;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rem;
        int exp_drop;

        vecs[0] = '{16'hA53C, 8'hA5, 8'h3C};
        vecs[1] = '{16'h0000, 8'h00, 8'h00};
        vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
        vecs[3] = '{16'h8001, 8'h80, 8'h01};
        vecs[4] = '{16'h1234, 8'h12, 8'h34};
        exp_drop = 0;

        // Reset for 3 cycles; a valid in the last one must lose to reset.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        valid = 1'b1;
        data  = 16'h1234;
        @(negedge clk);
        valid = 1'b0;
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset drop", {24'd0, drop}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle hold", {22'd0, tx, busy, drop}, {22'd0, 1'b1, 1'b0, 8'd0});
        end

        // Table-driven single words.
        for (int i = 0; i < 5; i++) begin
            start_q.delete();
            exp_q.push_back(vecs[i].b0);
            exp_q.push_back(vecs[i].b1);
            send(vecs[i].word);
            check("accept tx", {31'd0, tx}, 32'd0);
            check("accept busy", {31'd0, busy}, 32'd1);
            count_busy(n);
            check("busy length", n, BUSY);
            check("start count", start_q.size(), 2);
            if (start_q.size() == 2) check("byte spacing", start_q[1] - start_q[0], 10 * CPB);
            check("queue drained", exp_q.size(), 0);
        end

        // Drop while busy, then drop in the final gap cycle.
        start_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        send(16'hA53C);
        repeat (9) @(negedge clk);
        send(16'hFFFF);
        exp_drop++;
        check("drop mid", {24'd0, drop}, exp_drop);
        repeat (BUSY - 11) @(negedge clk);
        check("last gap busy", {31'd0, busy}, 32'd1);
        send(16'hFFFF);
        exp_drop++;
        check("drop last gap", {24'd0, drop}, exp_drop);
        check("first idle", {31'd0, busy}, 32'd0);

        // Back-to-back in the first idle cycle.
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h81);
        send(16'hC381);
        check("b2b tx", {31'd0, tx}, 32'd0);
        check("b2b busy", {31'd0, busy}, 32'd1);
        check("b2b drop", {24'd0, drop}, exp_drop);
        count_busy(n);
        check("b2b busy length", n, BUSY);
        check("b2b start count", start_q.size(), 4);
        if (start_q.size() == 4) check("word spacing", start_q[2] - start_q[1], 10 * CPB + DEAD + 1);
        check("b2b drained", exp_q.size(), 0);

        // Saturation: valid every cycle, busy model decides accept or drop.
        rem = 0;
        for (int i = 0; i < 300; i++) begin
            check("sat busy", {31'd0, busy}, {31'd0, rem > 0});
            check("sat drop", {24'd0, drop}, exp_drop);
            valid = 1'b1;
            data  = 16'($urandom);
            if (rem == 0) begin
                exp_q.push_back(data[15:8]);
                exp_q.push_back(data[7:0]);
                rem = BUSY;
            end else begin
                rem--;
                if (exp_drop < 255) exp_drop++;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        check("sat value", {24'd0, drop}, 32'd255);
        send(16'h0F0F);
        check("sat hold", {24'd0, drop}, 32'd255);
        count_busy(n);
        check("sat drained", exp_q.size(), 0);

        // Reset during data bit 3 of byte 0.
        start_q.delete();
        send(16'hA53C);
        repeat (34) @(negedge clk);
        check("bit3 level", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_drop = 0;
        check("midreset tx", {31'd0, tx}, 32'd1);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset drop", {24'd0, drop}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        send(16'h5AC3);
        check("post reset tx", {31'd0, tx}, 32'd0);
        count_busy(n);
        check("post reset busy length", n, BUSY);
        check("post reset drained", exp_q.size(), 0);
        check("post reset drop", {24'd0, drop}, exp_drop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
